// File: rtl/fifo_wr_128_to_64.sv
// Two-entry 128-bit buffer that feeds the 64-bit outbound write FIFO, high half first.
// Optional macro WORD_CNT_EN adds a 32-bit count of pushed halves on port wcnt.
module fifo_wr_128_to_64 #(
    parameter int i_r_width = 128,
    parameter int o_r_width = 64,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [i_r_width-1:0] idata,
    input  logic                 i_vld,
    output logic                 take,
    output logic [o_r_width-1:0] odata,
    output logic                 push,
    input  logic                 full,
    output logic                 busy
`ifdef WORD_CNT_EN
    ,
    output logic [31:0]          wcnt
`endif
);

    localparam logic [1:0] CNT_FULL = 2'(DEPTH);

    typedef enum logic {
        ST_HI = 1'b0,
        ST_LO = 1'b1
    } half_t;

    half_t                half_q, half_d;
    logic [i_r_width-1:0] buf0_q, buf0_d;
    logic [i_r_width-1:0] buf1_q, buf1_d;
    logic [i_r_width-1:0] rd_word;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 last_half;

    // A full buffer refuses input even if its last half leaves this cycle.
    always_comb begin
        take = i_vld && (cnt_q != CNT_FULL);
        push = (cnt_q != 2'd0) && !full;
        busy = (cnt_q != 2'd0);
    end

    always_comb begin
        rd_word = rd_ptr_q ? buf1_q : buf0_q;
    end

    always_comb begin
        half_d    = half_q;
        rd_ptr_d  = rd_ptr_q;
        last_half = 1'b0;
        odata     = rd_word[i_r_width-1:o_r_width];
        case (half_q)
            ST_HI: begin
                odata = rd_word[i_r_width-1:o_r_width];
                if (push) begin
                    half_d = ST_LO;
                end
            end
            ST_LO: begin
                odata = rd_word[o_r_width-1:0];
                if (push) begin
                    half_d    = ST_HI;
                    rd_ptr_d  = ~rd_ptr_q;
                    last_half = 1'b1;
                end
            end
            default: begin
                half_d = ST_HI;
            end
        endcase
    end

    always_comb begin
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        wr_ptr_d = wr_ptr_q;
        if (take) begin
            if (wr_ptr_q) begin
                buf1_d = idata;
            end else begin
                buf0_d = idata;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q + 2'(take) - 2'(last_half);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            half_q   <= ST_HI;
            buf0_q   <= '0;
            buf1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            half_q   <= half_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef WORD_CNT_EN
    logic [31:0] wcnt_q, wcnt_d;

    // Wraps naturally at 2^32 halves.
    always_comb begin
        wcnt_d = push ? (wcnt_q + 32'd1) : wcnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q <= 32'd0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign wcnt = wcnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_128_to_64.sv
// Scoreboard bench for fifo_wr_128_to_64: a cycle model predicts take/push/busy and
// a queue of expected halves is filled on each accepted word and drained on each push.
module tb_fifo_wr_128_to_64;

    logic         clk;
    logic         reset;
    logic [127:0] idata;
    logic         i_vld;
    logic         take;
    logic [63:0]  odata;
    logic         push;
    logic         full;
    logic         busy;
`ifdef WORD_CNT_EN
    logic [31:0]  wcnt;
`endif

    fifo_wr_128_to_64 dut (
        .clk   (clk),
        .reset (reset),
        .idata (idata),
        .i_vld (i_vld),
        .take  (take),
        .odata (odata),
        .push  (push),
        .full  (full),
        .busy  (busy)
`ifdef WORD_CNT_EN
        ,
        .wcnt  (wcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model and scoreboard, sampled on the falling edge.
    logic [63:0] sb[$];
    int          mcnt   = 0;
    bit          mhalf  = 0;
    int          ptotal = 0;
    int          cyc    = 0;
    int          last_push_cyc = -10;
    int          run     = 0;
    int          max_run = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        bit          e_take;
        bit          e_push;
        logic [63:0] e_data;
        if (reset) begin
            mcnt   = 0;
            mhalf  = 0;
            ptotal = 0;
            sb.delete();
            chk("rst_push", 128'(push), 128'(0));
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_odata", 128'(odata), 128'(0));
        end else begin
            e_take = i_vld && (mcnt != 2);
            e_push = (mcnt != 0) && !full;
            chk("take", 128'(take), 128'(e_take));
            chk("push", 128'(push), 128'(e_push));
            chk("busy", 128'(busy), 128'(mcnt != 0));
            if (e_push) begin
                ptotal++;
                run = (last_push_cyc == cyc - 1) ? run + 1 : 1;
                if (run > max_run) max_run = run;
                last_push_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 128'(1), 128'(0));
                end else begin
                    e_data = sb.pop_front();
                    chk("odata", 128'(odata), 128'(e_data));
                end
            end
            if (e_take) begin
                sb.push_back(idata[127:64]);
                sb.push_back(idata[63:0]);
            end
            mcnt = mcnt + int'(e_take) - int'(e_push && mhalf);
            if (e_push) mhalf = !mhalf;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_take(input string tag);
        bit got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (take) begin
                got = 1;
                break;
            end
        end
        if (!got) chk(tag, 128'(0), 128'(1));
    endtask

    task automatic drain(input string tag);
        bit idle = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1;
                break;
            end
        end
        if (!idle) chk(tag, 128'(0), 128'(1));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [127:0] W1 = 128'h0011223344556677_8899AABBCCDDEEFF;
    localparam logic [127:0] WA = 128'hA1A1A1A1A1A1A1A1_A2A2A2A2A2A2A2A2;
    localparam logic [127:0] WB = 128'hB1B1B1B1B1B1B1B1_B2B2B2B2B2B2B2B2;
    localparam logic [127:0] WC = 128'hC1C1C1C1C1C1C1C1_C2C2C2C2C2C2C2C2;
    localparam logic [127:0] WD = 128'hD1D1D1D1D1D1D1D1_D2D2D2D2D2D2D2D2;

    initial begin
        int p0;
        reset = 1'b1;
        i_vld = 1'b0;
        full  = 1'b0;
        idata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_take", 128'(take), 128'(0));
        step();
        reset = 1'b0;

        // Single word: take, hi, lo, idle
        i_vld = 1'b1;
        idata = W1;
        @(negedge clk);
        chk("t1_take_c0", 128'(take), 128'(1));
        step();
        i_vld = 1'b0;
        @(negedge clk);
        chk("t1_push_c1", 128'(push), 128'(1));
        chk("t1_odata_c1", 128'(odata), 128'(64'h0011223344556677));
        step();
        @(negedge clk);
        chk("t1_push_c2", 128'(push), 128'(1));
        chk("t1_odata_c2", 128'(odata), 128'(64'h8899AABBCCDDEEFF));
        step();
        @(negedge clk);
        chk("t1_busy_c3", 128'(busy), 128'(0));
        step();

        // Back-pressure with a full buffer
        full  = 1'b1;
        i_vld = 1'b1;
        idata = WA;
        wait_take("t2_take_a");
        step();
        idata = WB;
        wait_take("t2_take_b");
        step();
        idata = WC;
        @(negedge clk);
        chk("t2_c_blocked", 128'(take), 128'(0));
        chk("t2_no_push", 128'(push), 128'(0));
        chk("t2_busy", 128'(busy), 128'(1));
        step();
        full = 1'b0;
        @(negedge clk);
        chk("t2_a_hi", 128'(odata), 128'(WA[127:64]));
        chk("t2_take_hi", 128'(take), 128'(0));
        step();
        @(negedge clk);
        chk("t2_a_lo", 128'(odata), 128'(WA[63:0]));
        chk("t2_take_lo", 128'(take), 128'(0));
        step();
        @(negedge clk);
        chk("t2_c_taken", 128'(take), 128'(1));
        step();
        i_vld = 1'b0;
        drain("t2_drain");

        // full raised between the halves
        i_vld = 1'b1;
        idata = WA;
        wait_take("t3_take");
        step();
        i_vld = 1'b0;
        @(negedge clk);
        chk("t3_hi", 128'(odata), 128'(WA[127:64]));
        step();
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_push", 128'(push), 128'(0));
            chk("t3_hold_odata", 128'(odata), 128'(WA[63:0]));
            step();
        end
        full = 1'b0;
        @(negedge clk);
        chk("t3_lo_push", 128'(push), 128'(1));
        chk("t3_lo_odata", 128'(odata), 128'(WA[63:0]));
        step();
        @(negedge clk);
        chk("t3_once", 128'(push), 128'(0));
        step();

        // Eight words streamed back to back
        p0      = ptotal;
        max_run = 0;
        i_vld   = 1'b1;
        for (int w = 0; w < 8; w++) begin
            idata = {64'hE0E0_0000_0000_0000 | 64'(w), 64'h0E0E_0000_0000_0000 | 64'(w)};
            wait_take("t4_take");
            step();
        end
        i_vld = 1'b0;
        drain("t4_drain");
        chk("t4_push_count", 128'(ptotal - p0), 128'(16));
        chk("t4_push_run", 128'(max_run), 128'(16));
        chk("t4_sb_empty", 128'(sb.size()), 128'(0));
`ifdef WORD_CNT_EN
        chk("t4_wcnt", 128'(wcnt), 128'(ptotal));
`endif

        // Reset with two words buffered and the output on the low half
        full  = 1'b1;
        i_vld = 1'b1;
        idata = WA;
        wait_take("t5_take_a");
        step();
        idata = WB;
        wait_take("t5_take_b");
        step();
        i_vld = 1'b0;
        full  = 1'b0;
        @(negedge clk);
        chk("t5_a_hi", 128'(odata), 128'(WA[127:64]));
        step();
        full = 1'b1;
        @(negedge clk);
        chk("t5_lo_busy", 128'(busy), 128'(1));
        #2;
        reset = 1'b1;
        full  = 1'b0;
        #1;
        chk("t5_rst_push", 128'(push), 128'(0));
        chk("t5_rst_take", 128'(take), 128'(0));
        chk("t5_rst_busy", 128'(busy), 128'(0));
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_post_idle", 128'(push), 128'(0));
        step();
        i_vld = 1'b1;
        idata = WD;
        wait_take("t5_take_d");
        step();
        i_vld = 1'b0;
        @(negedge clk);
        chk("t5_d_hi_push", 128'(push), 128'(1));
        chk("t5_d_hi", 128'(odata), 128'(WD[127:64]));
        step();
        drain("t5_drain");

`ifdef WORD_CNT_EN
        // Counter wrap
        force dut.wcnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.wcnt_q;
        step();
        i_vld = 1'b1;
        idata = WC;
        wait_take("t6_take");
        step();
        i_vld = 1'b0;
        @(negedge clk);
        chk("t6_push", 128'(push), 128'(1));
        step();
        @(negedge clk);
        chk("t6_wcnt_wrap", 128'(wcnt), 128'(0));
        step();
        drain("t6_drain");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
